// File: rtl/rtc_pkg.sv
// Shared widths, field limits and the 12 h display helper for the RTC.
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // Returns {pm, hour_disp} for a 24 h hour value: 0 -> 12 AM, 13..23 -> 1..11 PM.
    function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] hour);
        logic              is_pm;
        logic [HOUR_W-1:0] disp;
        is_pm = (hour >= 5'd12);
        if (hour == 5'd0)
            disp = 5'd12;
        else if (hour > 5'd12)
            disp = hour - 5'd12;
        else
            disp = hour;
        return {is_pm, disp};
    endfunction

endpackage

// File: rtl/rtc_tick_prescaler.sv
// Divides clk down to a one-cycle wrap strobe every TICK_DIV enabled cycles.
module rtc_tick_prescaler #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic wrap
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    // The wrap strobe is only meaningful while counting; a frozen count never wraps.
    assign wrap = run && (cnt == LAST);

    // Count 0..TICK_DIV-1 while running; clear (a time load) restarts the second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (run)
            cnt <= (cnt == LAST) ? '0 : cnt + DIV_W'(1);
    end

endmodule

// File: rtl/timekeeper_rtc.sv
// 24 h real-time clock with load, range check, 12 h display, day and alarm pulses.
module timekeeper_rtc
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              mode_12h,
    input  logic              set_valid,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    input  logic [SEC_W-1:0]  set_sec,
    output logic              set_err,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    output logic [SEC_W-1:0]  second,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [HOUR_W-1:0] hour_disp,
    output logic              pm,
    output logic              tick,
    output logic              day_pulse,
    output logic              alarm_hit
);

    logic              wrap;
    logic              set_legal;
    logic              load_ok;
    logic              adv;
    logic [SEC_W-1:0]  sec_n;
    logic [MIN_W-1:0]  min_n;
    logic [HOUR_W-1:0] hour_n;
    logic              rollover;
    logic              alarm_match;
    logic [HOUR_W:0]   h12;

    // A load wins over a same-edge wrap, so the prescaler clear and the
    // advance suppression both key off load_ok.
    assign set_legal = (set_hour <= HOUR_MAX) && (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);
    assign load_ok   = set_valid && set_legal;
    assign adv       = wrap && !load_ok;

    rtc_tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (load_ok),
        .wrap  (wrap)
    );

    // Next time after one second; every field is compared before incrementing.
    always_comb begin
        sec_n    = second;
        min_n    = min;
        hour_n   = hour;
        rollover = 1'b0;
        if (second == SEC_MAX) begin
            sec_n = '0;
            if (min == MIN_MAX) begin
                min_n = '0;
                if (hour == HOUR_MAX) begin
                    hour_n   = '0;
                    rollover = 1'b1;
                end else begin
                    hour_n = hour + 5'd1;
                end
            end else begin
                min_n = min + 6'd1;
            end
        end else begin
            sec_n = second + 6'd1;
        end
    end

    // Matching against the advanced time means only a real advance can fire;
    // an out-of-range alarm can never equal a legal time.
    assign alarm_match = alarm_en && (hour_n == alarm_hour) && (min_n == alarm_min) && (sec_n == '0);

    // Time registers and the one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            second    <= '0;
            min       <= '0;
            hour      <= '0;
            tick      <= 1'b0;
            day_pulse <= 1'b0;
            alarm_hit <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            tick      <= adv;
            day_pulse <= adv && rollover;
            alarm_hit <= adv && alarm_match;
            set_err   <= set_valid && !set_legal;
            if (load_ok) begin
                second <= set_sec;
                min    <= set_min;
                hour   <= set_hour;
            end else if (adv) begin
                second <= sec_n;
                min    <= min_n;
                hour   <= hour_n;
            end
        end
    end

    // Display conversion is purely combinational from the stored 24 h hour.
    assign h12       = to_12h(hour);
    assign pm        = h12[HOUR_W];
    assign hour_disp = mode_12h ? h12[HOUR_W-1:0] : hour;

endmodule

// File: tb/tb_timekeeper_rtc.sv
// Scoreboard bench for timekeeper_rtc: a seconds-of-day reference model
// predicts every tick, pulse and set_err; a monitor checks them at negedge.
module tb_timekeeper_rtc;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic [5:0] set_sec = '0;
    logic       set_err;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_min = '0;
    logic [5:0] second;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic       pm;
    logic       tick;
    logic       day_pulse;
    logic       alarm_hit;

    int checks = 0;
    int errors = 0;

    timekeeper_rtc #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
        .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_err(set_err), .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .second(second), .min(min), .hour(hour), .hour_disp(hour_disp), .pm(pm),
        .tick(tick), .day_pulse(day_pulse), .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (time as seconds of the day) ----------------
    typedef struct { int t; bit day; bit al; } exp_t;
    exp_t exp_q[$];
    int   m_t = 0, m_pre = 0;
    bit   m_err = 0;
    int   n_day_exp = 0, n_al_exp = 0, n_day_got = 0, n_al_got = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t = 0; m_pre = 0; m_err = 0;
            exp_q.delete();
        end else begin
            bit   legal;
            exp_t e;
            legal = (set_hour < 24) && (set_min < 60) && (set_sec < 60);
            m_err = set_valid && !legal;
            if (set_valid && legal) begin
                m_t   = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
                m_pre = 0;
            end else if (run) begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    m_t   = (m_t + 1) % 86400;
                    e.t   = m_t;
                    e.day = (m_t == 0);
                    e.al  = alarm_en && (alarm_hour < 24) && (alarm_min < 60)
                            && (m_t == int'(alarm_hour) * 3600 + int'(alarm_min) * 60);
                    exp_q.push_back(e);
                    if (e.day) n_day_exp++;
                    if (e.al)  n_al_exp++;
                end else begin
                    m_pre++;
                end
            end
        end
    end

    function automatic int exp_disp(input int h, input bit m12);
        if (!m12)    return h;
        if (h == 0)  return 12;
        if (h > 12)  return h - 12;
        return h;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (tick) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_tick", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tick_day_pulse", int'(day_pulse), int'(e.day));
                    chk("tick_alarm_hit", int'(alarm_hit), int'(e.al));
                end
            end else begin
                chk("missing_tick", exp_q.size(), 0);
                exp_q.delete();
                chk("day_pulse_no_tick", int'(day_pulse), 0);
                chk("alarm_hit_no_tick", int'(alarm_hit), 0);
            end
            if (day_pulse) n_day_got++;
            if (alarm_hit) n_al_got++;
            chk("set_err", int'(set_err), int'(m_err));
            chk("time", int'(hour) * 3600 + int'(min) * 60 + int'(second), m_t);
            chk("hour_disp", int'(hour_disp), exp_disp(m_t / 3600, mode_12h));
            chk("pm", int'(pm), int'(m_t >= 12 * 3600));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic load(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
        cyc(1);
        set_valid = 1'b0;
    endtask

    // Returns cycles until tick is seen at a negedge; bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 40);
        if (!tick) chk("tick_timeout", n, -1);
        #1;
    endtask

    int n;
    int hs[5] = '{0, 11, 12, 13, 23};
    int ds[5] = '{12, 11, 12, 1, 11};
    int ps[5] = '{0, 0, 1, 1, 1};

    initial begin
        // Reset state
        #2;
        chk("rst_second", int'(second), 0);
        chk("rst_tick", int'(tick), 0);
        cyc(2);
        reset = 1'b0;
        run = 1'b1;
        load(5, 6, 7);
        cyc(6);

        // Reset mid-count: outputs clear immediately, first tick 4 cycles after release
        reset = 1'b1;
        #1;
        chk("midrst_time", int'(hour) + int'(min) + int'(second), 0);
        chk("midrst_pulses", int'(tick) + int'(day_pulse) + int'(alarm_hit) + int'(set_err), 0);
        cyc(2);
        reset = 1'b0;
        wait_tick(n);
        chk("first_tick_latency", n, 4);
        chk("first_tick_second", int'(second), 1);

        // Load and wrap on the same edge: load wins, next tick 4 cycles later
        cyc(2);
        load(1, 2, 3);
        chk("same_edge_load_time", int'(hour) * 3600 + int'(min) * 60 + int'(second), 3723);
        wait_tick(n);
        chk("after_load_latency", n, 4);
        chk("after_load_second", int'(second), 4);

        // Day rollover
        load(23, 59, 58);
        wait_tick(n);
        wait_tick(n);
        chk("rollover_time", int'(hour) + int'(min) + int'(second), 0);
        chk("rollover_day_pulse", int'(day_pulse), 1);
        cyc(1);
        chk("day_pulse_one_cycle", int'(day_pulse), 0);

        // Illegal loads leave time and prescaler alone
        load(10, 20, 30);
        cyc(1);
        load(10, 60, 0);
        chk("illegal_min_err", int'(set_err), 1);
        load(24, 0, 0);
        chk("illegal_hour_err", int'(set_err), 1);
        cyc(1);
        chk("err_one_cycle", int'(set_err), 0);

        // Alarm fires on advance only, not on load
        alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        load(7, 29, 59);
        wait_tick(n);
        chk("alarm_fire", int'(alarm_hit), 1);
        load(7, 30, 0);
        chk("alarm_on_load", int'(alarm_hit), 0);
        wait_tick(n);
        chk("alarm_after_load", int'(alarm_hit), 0);

        // run=0 freezes everything
        run = 1'b0;
        cyc(10);
        run = 1'b1;
        cyc(6);

        // 12 h display sweep
        run = 1'b0;
        mode_12h = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load(hs[i], 0, 0);
            chk("disp12", int'(hour_disp), ds[i]);
            chk("pm12", int'(pm), ps[i]);
        end
        mode_12h = 1'b0;
        run = 1'b1;

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 63) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 199) == 0) begin
                alarm_en   = ($urandom_range(0, 3) != 0);
                alarm_hour = 5'($urandom_range(0, 26));
                alarm_min  = 6'($urandom_range(0, 62));
            end
            if ($urandom_range(0, 24) == 0) begin
                int sel;
                sel = $urandom_range(0, 3);
                set_valid = 1'b1;
                if (sel == 0) begin
                    set_hour = 5'($urandom_range(0, 31));
                    set_min  = 6'($urandom_range(0, 63));
                    set_sec  = 6'($urandom_range(0, 63));
                end else if (sel == 1 && alarm_min > 0 && alarm_hour < 24) begin
                    set_hour = alarm_hour;
                    set_min  = alarm_min - 6'd1;
                    set_sec  = 6'($urandom_range(57, 59));
                end else if (sel == 2) begin
                    set_hour = 5'd23; set_min = 6'd59;
                    set_sec  = 6'($urandom_range(56, 59));
                end else begin
                    set_hour = 5'($urandom_range(0, 23));
                    set_min  = 6'($urandom_range(0, 59));
                    set_sec  = 6'($urandom_range(0, 59));
                end
            end else begin
                set_valid = 1'b0;
            end
            cyc(1);
        end
        set_valid = 1'b0;
        cyc(3);

        chk("day_pulse_count", n_day_got, n_day_exp);
        chk("alarm_hit_count", n_al_got, n_al_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timekeeper_rtc.md
Name: timekeeper_rtc

Overview:
Parametrised real-time clock. An internal prescaler divides clk into 1 Hz ticks, and the block keeps hours/minutes/seconds in 24 h binary form. Adds run/stop control, synchronous time load with range check, 12/24 h display conversion, a day-rollover pulse and a minute-resolution alarm. Sits between the system clock domain and display/alarm logic.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick (>=2).
DIV_W, 26, prescaler counter width; must satisfy 2**DIV_W >= TICK_DIV.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
run  in  1  1 = prescaler counts; 0 = prescaler and time frozen
mode_12h  in  1  1 = hour_disp/pm in 12 h form; 0 = 24 h form
set_valid  in  1  load request, sampled each edge
set_hour  in  5  load value, legal 0..23
set_min  in  6  load value, legal 0..59
set_sec  in  6  load value, legal 0..59
set_err  out  1  one-cycle pulse: load rejected, out of range
alarm_en  in  1  alarm enable
alarm_hour  in  5  alarm hour 0..23
alarm_min  in  6  alarm minute 0..59
second  out  6  seconds 0..59
min  out  6  minutes 0..59
hour  out  5  hours, always 24 h, 0..23
hour_disp  out  5  display hour (combinational from hour, mode_12h)
pm  out  1  1 when hour >= 12 (combinational)
tick  out  1  one-cycle pulse, registered, on each second advance
day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
alarm_hit  out  1  one-cycle pulse when time reaches alarm

Behaviour:
- Reset (async assert): second=min=hour=0, prescaler=0, tick=day_pulse=alarm_hit=set_err=0. Release is synchronous to clk.
- Prescaler: when run=1, counts 0..TICK_DIV-1. On the edge where it equals TICK_DIV-1, it wraps to 0 and the time advances in that same edge. tick is high for the following cycle.
- run=0: prescaler holds its value and time holds. Resuming continues from the held count, with no extra tick.
- Advance: second+1. At 59, second wraps to 0 and min+1. At min 59, min wraps to 0 and hour+1. At hour 23, hour wraps to 0 and day_pulse is high for one cycle, aligned with tick.
- Load: when set_valid=1 and all set_* fields are legal, load hour/min/sec on that edge and clear the prescaler to 0. No tick, day_pulse or alarm_hit is generated.
- Illegal load (any field out of range): time and prescaler are unchanged, and set_err is high for the next cycle.
- Load and a prescaler wrap on the same edge: the load wins and the tick is dropped. Loads are accepted regardless of run.
- Alarm: alarm_hit is high for one cycle, aligned with tick, when alarm_en=1 and the advance produces hour==alarm_hour, min==alarm_min, second==0.
  - It fires once per match; a load onto the alarm time does not fire.
  - An out-of-range alarm setting never matches.
- hour_disp:
  - mode_12h=0: equals hour.
  - mode_12h=1: hour 0 gives 12; hours 1..12 are unchanged; hours 13..23 give hour-12.
- pm = (hour>=12) in both modes.
- All arithmetic is unsigned. Compare before incrementing; never rely on width overflow.

Decomposition:
- Package rtc_pkg: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, SEC_W=6, HOUR_W=5, and function to_12h(hour) returning {pm, hour_disp}.
- One sub-module, rtc_tick_prescaler (parameters TICK_DIV, DIV_W; ports clk, reset, run, clear, wrap). Time counters, load, alarm and pulses stay in the top module.

Test Plan (TICK_DIV=4):
- Reset mid-count at 05:06:07 -> all outputs 0 immediately; after release, first tick comes exactly 4 cycles later with second=1.
- Load 23:59:58, run=1 -> after 2 ticks the time is 00:00:00; day_pulse is high for exactly one cycle, coincident with tick.
- set_valid with set_min=60 at 10:20:30 -> time unchanged, prescaler unchanged, set_err high one cycle; then set_hour=24 -> same result.
- Alarm 07:30, alarm_en=1, load 07:29:59 -> alarm_hit on the next tick only; load 07:30:00 again -> no alarm_hit.
- Set and wrap on the same edge: load 01:02:03 -> time 01:02:03, no tick; next tick 4 cycles later gives 01:02:04.
- run=0 for 10 cycles mid-count -> no tick and time frozen; mode_12h=1 sweep of hours 0/11/12/13/23 -> hour_disp 12/11/12/1/11, pm 0/0/1/1/1.
